// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement add/sub, one carry slice per stage; latency STAGES cycles.
// Global stall: all stages hold while the output beat is presented and not taken.
module add_sub_pipe #(
  parameter int WIDTH    = 16,
  parameter int STAGES   = 2,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SW = WIDTH / STAGES;

  logic             w_adv;
  logic             r_out_vld;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  assign w_adv     = !r_out_vld || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_vld;
  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

  // Each stage consumes the low slice of its operand word. The A/sum word rotates
  // right by SW so finished sum slices fill in from the top; B' shrinks by SW.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [WIDTH-1:0]      w_x_in;
    logic [WIDTH-k*SW-1:0] w_b_in;
    logic                  w_c_in;
    logic                  w_v_in;
    logic [SW:0]           w_slice;

    if (k == 0) begin : g_src
      assign w_x_in = a;
      assign w_b_in = sub ? ~b : b;
      assign w_c_in = sub;
      assign w_v_in = in_valid;
    end else begin : g_chain
      assign w_x_in = g_st[k-1].g_reg.r_x;
      assign w_b_in = g_st[k-1].g_reg.r_b;
      assign w_c_in = g_st[k-1].g_reg.r_c;
      assign w_v_in = g_st[k-1].g_reg.r_v;
    end

    assign w_slice = {1'b0, w_x_in[SW-1:0]} + {1'b0, w_b_in[SW-1:0]} + {{SW{1'b0}}, w_c_in};

    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-1:0]          r_x;
      logic [WIDTH-(k+1)*SW-1:0] r_b;
      logic                      r_c;
      logic                      r_v;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_x <= '0;
          r_b <= '0;
          r_c <= 1'b0;
          r_v <= 1'b0;
        end else if (w_adv) begin
          r_x <= {w_slice[SW-1:0], w_x_in[WIDTH-1:SW]};
          r_b <= w_b_in[WIDTH-k*SW-1:SW];
          r_c <= w_slice[SW];
          r_v <= w_v_in;
        end
      end
    end else begin : g_fin
      logic [WIDTH-1:0] w_raw;
      logic [WIDTH-1:0] w_sat;
      logic [WIDTH-1:0] w_res;
      logic             w_ovf;

      if (STAGES == 1) begin : g_one
        assign w_raw = w_slice[SW-1:0];
      end else begin : g_many
        assign w_raw = {w_slice[SW-1:0], w_x_in[WIDTH-1:SW]};
      end

      // Low slice of w_x_in still holds A's top slice here, so its MSB is A[MSB].
      assign w_ovf = (w_x_in[SW-1] == w_b_in[SW-1]) && (w_slice[SW-1] != w_x_in[SW-1]);
      assign w_sat = {w_x_in[SW-1], {(WIDTH-1){~w_x_in[SW-1]}}};
      assign w_res = (SATURATE && w_ovf) ? w_sat : w_raw;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_out_vld <= 1'b0;
          r_sum     <= '0;
          r_cout    <= 1'b0;
          r_ovf     <= 1'b0;
        end else if (w_adv) begin
          r_out_vld <= w_v_in;
          r_sum     <= w_res;
          r_cout    <= w_slice[SW];
          r_ovf     <= w_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Directed vectors on 16/2 wrap+saturate instances, streaming/stall/reset sequences,
// and randomized scoreboard runs over several STAGES/SATURATE configurations.
module tb_add_sub_pipe;

  localparam int NRND = 2500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv, isub, ordy;
  logic [15:0] ia, ib;
  logic        in_ready0, in_ready1;
  logic        o0_vld, o0_c, o0_v, o1_vld, o1_c, o1_v;
  logic [15:0] o0_sum, o1_sum;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_go  = 1'b0;
  bit rnd_done [4];

  always #5 clk = ~clk;

  add_sub_pipe #(.WIDTH(16), .STAGES(2), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(in_ready0), .a(ia), .b(ib), .sub(isub),
    .out_valid(o0_vld), .out_ready(ordy), .sum(o0_sum), .carry_out(o0_c), .overflow(o0_v));

  add_sub_pipe #(.WIDTH(16), .STAGES(2), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(in_ready1), .a(ia), .b(ib), .sub(isub),
    .out_valid(o1_vld), .out_ready(ordy), .sum(o1_sum), .carry_out(o1_c), .overflow(o1_v));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input bit sat);
    logic [15:0] yp;
    logic [16:0] f;
    logic [15:0] r;
    logic        ov;
    yp = s ? ~y : y;
    f  = {1'b0, x} + {1'b0, yp} + {16'b0, s};
    ov = (x[15] == yp[15]) && (f[15] != x[15]);
    r  = f[15:0];
    if (sat && ov) r = x[15] ? 16'h8000 : 16'h7FFF;
    return {r, f[16], ov};
  endfunction

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] e_wrap;
    logic [15:0] e_sat;
    logic        e_c;
    logic        e_v;
    string       nm;
  } vec_t;

  vec_t vt [8];

  task automatic send_one(input vec_t v);
    @(negedge clk);
    iv = 1'b1; ia = v.a; ib = v.b; isub = v.s;
    #1 chk({v.nm, "/in_ready"}, in_ready0, 1);
    @(negedge clk);
    iv = 1'b0;
    #1 chk({v.nm, "/lat1_vld"}, o0_vld, 0);
    @(negedge clk);
    #1;
    chk({v.nm, "/vld"},      o0_vld, 1);
    chk({v.nm, "/sum"},      o0_sum, v.e_wrap);
    chk({v.nm, "/carry"},    o0_c,   v.e_c);
    chk({v.nm, "/ovf"},      o0_v,   v.e_v);
    chk({v.nm, "/sat_vld"},  o1_vld, 1);
    chk({v.nm, "/sat_sum"},  o1_sum, v.e_sat);
    chk({v.nm, "/sat_ovf"},  o1_v,   v.e_v);
  endtask

  initial begin
    int i, j;
    vt[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0, "slice_carry"};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, "wrap_carry"};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, "pos_ovf"};
    vt[3] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, "sub_borrow"};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1, "sub_neg_ovf"};
    vt[5] = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0, "sub_noborrow"};
    vt[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1, "neg_ovf"};
    vt[7] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 16'h2345, 1'b0, 1'b0, "plain_add"};

    rst_n = 1'b0; iv = 1'b0; isub = 1'b0; ia = '0; ib = '0; ordy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst/vld",      o0_vld,    0);
    chk("rst/sum",      o0_sum,    0);
    chk("rst/carry",    o0_c,      0);
    chk("rst/ovf",      o0_v,      0);
    chk("rst/in_ready", in_ready0, 1);
    chk("rst/sat_vld",  o1_vld,    0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) send_one(vt[k]);

    // Back-to-back stream with a 3-cycle output stall.
    i = 0; j = 0;
    for (int cyc = 0; cyc < 60 && j < 8; cyc++) begin
      @(negedge clk);
      ordy = !(cyc >= 4 && cyc <= 6);
      if (i < 8) begin
        iv = 1'b1; ia = 16'(i); ib = 16'(16'h1000 * i); isub = 1'b0;
      end else begin
        iv = 1'b0;
      end
      #1;
      chk("stream/in_ready", in_ready0, ordy);
      if (o0_vld) chk("stream/sum", o0_sum, 32'h1001 * j);
      if (o0_vld && ordy) j++;
      if (iv && in_ready0) i++;
    end
    chk("stream/count", j, 8);
    iv = 1'b0; ordy = 1'b1;

    // Reset with two beats in flight.
    @(negedge clk);
    iv = 1'b1; ia = 16'h0001; ib = 16'h0001; isub = 1'b0;
    @(negedge clk);
    ia = 16'h0002; ib = 16'h0002;
    @(negedge clk);
    iv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst/vld", o0_vld, 0);
    chk("midrst/sum", o0_sum, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("midrst/stale", o0_vld, 0);
    end
    send_one(vt[7]);

    rnd_go = 1'b1;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(negedge clk);
      if (rnd_done[0] && rnd_done[1] && rnd_done[2] && rnd_done[3]) break;
    end
    chk("rnd/all_done", {rnd_done[0], rnd_done[1], rnd_done[2], rnd_done[3]}, 4'hF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 4; g++) begin : g_rnd
    localparam int ST  = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
    localparam bit SAT = (g == 0 || g == 3);

    logic        rv, rr, rs, irdy, ovld, oc, oo;
    logic [15:0] ra, rb, osum;

    add_sub_pipe #(.WIDTH(16), .STAGES(ST), .SATURATE(SAT)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(irdy), .a(ra), .b(rb), .sub(rs),
      .out_valid(ovld), .out_ready(rr), .sum(osum), .carry_out(oc), .overflow(oo));

    initial begin
      logic [17:0] q[$];
      logic [17:0] e;
      int sent, got;
      rv = 1'b0; rr = 1'b1; rs = 1'b0; ra = '0; rb = '0;
      sent = 0; got = 0;
      wait (rnd_go);
      for (int cyc = 0; cyc < 20000 && got < NRND; cyc++) begin
        @(negedge clk);
        rr = ($urandom_range(3) != 0);
        if (sent < NRND) begin
          rv = ($urandom_range(3) != 0);
          ra = 16'($urandom);
          rb = 16'($urandom);
          rs = 1'($urandom_range(1));
        end else begin
          rv = 1'b0;
        end
        #1;
        if (ovld && rr) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rnd%0d/extra: got sum %h with no beat outstanding", g, osum);
          end else begin
            e = q.pop_front();
            chk($sformatf("rnd%0d/result", g), {osum, oc, oo}, e);
          end
          got++;
        end
        if (rv && irdy) begin
          q.push_back(model(ra, rb, rs, SAT));
          sent++;
        end
      end
      chk($sformatf("rnd%0d/count", g), got, NRND);
      chk($sformatf("rnd%0d/leftover", g), q.size(), 0);
      rnd_done[g] = 1'b1;
    end
  end

endmodule

// File: doc/add_sub_pipe.md
Name: add_sub_pipe

Overview:
Parametrised, pipelined two's-complement adder/subtractor with carry, signed-overflow and optional signed saturation. It generalises the team's 16-bit combinational adder for wide datapaths in the multiplier (partial-product accumulation, final carry-propagate add). The add is split into STAGES carry-chained slices, one slice per pipeline stage. A valid/ready handshake on both sides allows backpressure from downstream consumers.

Parameters:
WIDTH, 16, operand/result width in bits (≥2)
STAGES, 2, pipeline stages = carry slices; WIDTH % STAGES must be 0; slice width SW = WIDTH/STAGES
SATURATE, 0, 1 = clamp signed overflow to 2^(WIDTH-1)-1 / -2^(WIDTH-1); 0 = wrap

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand beat present
in_ready  out  1  block accepts beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
sub  in  1  0: A+B, 1: A−B (sampled with operands)
out_valid  out  1  result beat present
out_ready  in  1  downstream accepts result
sum  out  WIDTH  result (wrapped or saturated)
carry_out  out  1  unsigned carry out of MSB; for sub = 1 when A ≥ B unsigned (no borrow)
overflow  out  1  signed overflow of the unsaturated result (set even when SATURATE clamps)

Behaviour:
- Reset (async assert, sync release via rst_n): all stage valid bits, out_valid, sum, carry_out and overflow = 0; in_ready = 1 after reset.
- Accept: beat transferred when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Global stall: adv = !out_valid || out_ready. in_ready = adv (combinational). When adv = 0 all stage registers, including valid bits and operands, hold.
- Operation: B' = sub ? ~b : b; cin = sub. Stage k (0..STAGES−1) adds slice k of A and B' plus the carry registered from stage k−1 (cin for k = 0). It registers the SW-bit partial sum and carry. Higher slices of A/B' and the already-computed lower sum slices are carried forward in stage registers.
- Final stage: carry_out = carry of the top slice. overflow = (A[MSB] == B'[MSB]) && (raw[MSB] != A[MSB]). If SATURATE and overflow, sum = A[MSB] ? {1,0…0} : {0,1…1}; else sum = raw.
- Latency: result for a beat accepted at edge N is valid after edge N+STAGES when no stall occurs. Throughput: 1 beat/cycle with out_ready held high. Stall cycles add 1:1 latency. Order is preserved; no beat is dropped or duplicated.
- Bubbles: invalid stages advance when adv = 1. The pipeline is not compacted while stalled.
- Outputs are registered. sum, carry_out and overflow are stable while out_valid && !out_ready.
- Reset mid-operation discards every in-flight beat. out_valid = 0 immediately on rst_n low.
- STAGES = 1 degenerates to a single registered add with latency 1.
- Operand and sub values are don't-care when in_valid = 0. Invalid stages need not be zeroed.

Test Plan:
Use WIDTH = 16, STAGES = 2 (SW = 8), out_ready = 1 unless stated.
1. Slice carry: a=0x00FF, b=0x0001, sub=0 → sum=0x0100, carry_out=0, overflow=0, out_valid two cycles after accept.
2. Wrap and carry: a=0xFFFF, b=0x0001, sub=0 → sum=0x0000, carry_out=1, overflow=0. Then a=0x7FFF, b=0x0001 → sum=0x8000, overflow=1 (SATURATE=0); with SATURATE=1 → sum=0x7FFF, overflow=1.
3. Subtract: a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, carry_out=0, overflow=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, overflow=1; with SATURATE=1 → sum=0x8000.
4. Streaming and backpressure: send 8 back-to-back beats (a=i, b=0x1000·i); drop out_ready for 3 cycles mid-stream → in_ready low exactly while out_valid && !out_ready. All 8 results arrive in order with held values during the stall and no loss.
5. Reset mid-stream: assert rst_n low with 2 beats in flight → out_valid=0 and sum=0 immediately. After release, a fresh beat a=0x1234, b=0x1111 → sum=0x2345 at latency 2; no stale beats emerge.
6. Random check: 10k random a, b, sub and random out_ready across STAGES ∈ {1,2,4} and SATURATE ∈ {0,1}. Compare against a reference model for sum, carry_out and overflow, and check the beat count matches.
